// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int CLK_DIV_9600_50M = 5208;

    // Counter/index width for n distinct values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NREQ requesters; the last-granted pointer advances only on accept.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = width_of(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] sel,
    output logic            valid
);

    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] last_d;
    logic [ID_W-1:0] idx;

    // Search last+1, last+2, ... so the most recent winner has lowest priority.
    always_comb begin
        gnt   = '0;
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = ID_W'((int'(last_q) + k) % NREQ);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                sel   = idx;
            end
        end
        if (valid) begin
            gnt[sel] = 1'b1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= ID_W'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_rr_sched.sv
// One UART TX line shared by NREQ byte requesters: round-robin grant, then start/data/stop framing.
module uart_tx_rr_sched
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_9600_50M,
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    localparam int ID_W   = width_of(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic [ID_W-1:0]        cur_id,
    output logic                   tx,
    output state_e                 state_dbg
);

    localparam int BAUD_W = width_of(CLK_DIV);
    localparam int BIT_W  = width_of(DATA_W);

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic                tx_q, tx_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [ID_W-1:0]     arb_sel;
    logic                arb_valid;
    logic                accept;
    logic                bit_end;

    // Grant is decided and issued in the same IDLE cycle so a request dropped
    // before that cycle is never served; hence gnt/busy are not registered.
    assign accept = (state_q == IDLE) && arb_valid && !rst;
    assign bit_end = (baud_q == BAUD_W'(CLK_DIV - 1));

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .gnt    (arb_gnt),
        .sel    (arb_sel),
        .valid  (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (accept) begin
                    state_d  = START;
                    shift_d  = req_data[arb_sel*DATA_W +: DATA_W];
                    cur_id_d = arb_sel;
                    bit_d    = '0;
                end
            end
            START: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        // tx is registered from the next state so the line matches the state it enters.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            cur_id_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            cur_id_q <= cur_id_d;
            tx_q     <= tx_d;
        end
    end

    assign gnt       = accept ? arb_gnt : '0;
    assign busy      = (state_q != IDLE) || accept;
    assign cur_id    = cur_id_q;
    assign tx        = tx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_rr_sched.sv
// Directed bench: a fast instance (CLK_DIV=4) for arbitration/framing and a default-rate instance for bit timing.
module tb_uart_tx_rr_sched;
    import uart_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int DIV  = 4;
    localparam int FRM  = (DW + 2) * DIV;
    localparam int DIVB = 5208;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req_a = '0;
    logic [NREQ-1:0]  req_b = '0;
    logic [NREQ*DW-1:0] data_a = '0;
    logic [NREQ*DW-1:0] data_b = '0;

    logic [NREQ-1:0]  gnt_a, gnt_b;
    logic             busy_a, busy_b;
    logic [1:0]       cur_id_a, cur_id_b;
    logic             tx_a, tx_b;
    state_e           st_a, st_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;
    int busy_cnt = 0;
    logic exp_q[$];

    uart_tx_rr_sched #(.CLK_DIV(DIV), .NREQ(NREQ), .DATA_W(DW)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_data(data_a), .gnt(gnt_a),
        .busy(busy_a), .cur_id(cur_id_a), .tx(tx_a), .state_dbg(st_a)
    );

    uart_tx_rr_sched #(.CLK_DIV(DIVB), .NREQ(NREQ), .DATA_W(DW)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_data(data_b), .gnt(gnt_b),
        .busy(busy_b), .cur_id(cur_id_b), .tx(tx_b), .state_dbg(st_b)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Inputs change just after posedge; outputs are sampled on negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        req_a = '0;
        next_cycle();
        next_cycle();
        sample();
        check("rst_tx", tx_a, 1);
        check("rst_gnt", gnt_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_cur_id", cur_id_a, 0);
        check("rst_state", st_a, IDLE);
    endtask

    // Caller has applied req for the current cycle; returns at negedge of the grant cycle.
    task automatic wait_grant(input int budget, output logic [NREQ-1:0] g, output int at);
        g  = '0;
        at = -1;
        sample();
        for (int i = 0; i < budget; i++) begin
            if (gnt_a != '0) begin
                g  = gnt_a;
                at = cyc_n;
                check("grant_busy", busy_a, 1);
                check("grant_tx_idle", tx_a, 1);
                busy_cnt = 1;
                return;
            end
            next_cycle();
            sample();
        end
        check("grant_timeout", 0, 1);
    endtask

    // Runs ncyc cycles of a frame after the grant, checking tx against the expected bit stream.
    task automatic frame_chk(input logic [DW-1:0] b, input int ncyc,
                             input logic [NREQ-1:0] r_early, input logic [NREQ-1:0] r_mid,
                             input logic [NREQ-1:0] r_late);
        logic e;
        exp_q.delete();
        for (int k = 0; k < DIV; k++) exp_q.push_back(1'b0);
        for (int j = 0; j < DW; j++)
            for (int k = 0; k < DIV; k++) exp_q.push_back(b[j]);
        for (int k = 0; k < DIV; k++) exp_q.push_back(1'b1);
        for (int c = 1; c <= ncyc; c++) begin
            next_cycle();
            req_a = (c <= 13) ? r_early : (c <= 27) ? r_mid : r_late;
            sample();
            e = exp_q.pop_front();
            check("tx_bit", tx_a, e);
            check("busy_frame", busy_a, 1);
            check("gnt_in_frame", gnt_a, 0);
            if (busy_a) busy_cnt++;
        end
    endtask

    logic [NREQ-1:0] g;
    int at, prev;
    int run_ok[10];
    logic [9:0] fb;

    initial begin
        // Single byte from requester 1
        do_reset();
        next_cycle();
        rst = 1'b0;
        req_a = 4'b0010;
        data_a = {8'h33, 8'h22, 8'hA5, 8'h00};
        wait_grant(5, g, at);
        check("single_gnt", g, 4'b0010);
        frame_chk(8'hA5, FRM, 4'b0000, 4'b0000, 4'b0000);
        check("single_cur_id", cur_id_a, 1);
        next_cycle();
        sample();
        check("single_busy_after", busy_a, 0);
        check("single_tx_after", tx_a, 1);
        check("single_busy_len", busy_cnt, FRM + 1);

        // All requesters held: order 0,1,2,3 spaced one frame plus one idle cycle
        do_reset();
        next_cycle();
        rst = 1'b0;
        req_a = 4'b1111;
        data_a = {8'h33, 8'h22, 8'h11, 8'h00};
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(FRM + 10, g, at);
            check("all_order", g, 32'(1 << k));
            if (k > 0) check("all_spacing", at - prev, FRM + 1);
            prev = at;
            frame_chk(data_a[k*DW +: DW], FRM, 4'b1111, 4'b1111, (k == 3) ? 4'b0000 : 4'b1111);
            check("all_cur_id", cur_id_a, k);
        end
        next_cycle();
        sample();
        check("all_no_more_gnt", gnt_a, 0);
        check("all_idle_tx", tx_a, 1);

        // Reset during data bit 3 of a frame for requester 1
        next_cycle();
        req_a = 4'b0010;
        data_a = {8'h33, 8'h22, 8'h37, 8'hC3};
        wait_grant(5, g, at);
        check("abort_gnt", g, 4'b0010);
        frame_chk(8'h37, 19, 4'b1111, 4'b1111, 4'b1111);
        next_cycle();
        rst = 1'b1;
        sample();
        check("abort_pre_tx", tx_a, 0);
        next_cycle();
        sample();
        check("abort_tx", tx_a, 1);
        check("abort_busy", busy_a, 0);
        check("abort_state", st_a, IDLE);
        check("abort_gnt_in_rst", gnt_a, 0);
        next_cycle();
        rst = 1'b0;
        wait_grant(5, g, at);
        check("abort_next_gnt", g, 4'b0001);

        // Requester 3 pulsed only mid-frame must never be granted
        frame_chk(8'hC3, FRM, 4'b0000, 4'b1000, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            sample();
            check("withdrawn_gnt", gnt_a, 0);
            check("withdrawn_tx", tx_a, 1);
        end
        check("withdrawn_busy", busy_a, 0);

        // Fairness between requesters 0 and 2
        do_reset();
        next_cycle();
        rst = 1'b0;
        req_a = 4'b0101;
        data_a = {8'h00, 8'h3C, 8'h00, 8'h81};
        for (int k = 0; k < 6; k++) begin
            wait_grant(FRM + 10, g, at);
            check("fair_order", g, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            frame_chk((k % 2 == 0) ? 8'h81 : 8'h3C, FRM, 4'b0101, 4'b0101,
                      (k == 5) ? 4'b0000 : 4'b0101);
        end

        // Default bit timing, byte 0x55 on requester 0
        fb = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) run_ok[i] = 0;
        next_cycle();
        req_b = 4'b0001;
        data_b = {8'h00, 8'h00, 8'h00, 8'h55};
        sample();
        check("slow_gnt", gnt_b, 4'b0001);
        check("slow_busy_gnt", busy_b, 1);
        busy_cnt = 0;
        for (int c = 1; c <= 10 * DIVB; c++) begin
            next_cycle();
            req_b = '0;
            sample();
            if (tx_b === fb[(c - 1) / DIVB]) run_ok[(c - 1) / DIVB]++;
            if (busy_b) busy_cnt++;
        end
        for (int i = 0; i < 10; i++) check("slow_bit_len", run_ok[i], DIVB);
        check("slow_frame_len", busy_cnt, 10 * DIVB);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            sample();
            check("slow_idle_tx", tx_b, 1);
            check("slow_idle_busy", busy_b, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
